dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU datapath and the 32-bit-block data memory.
- Serves byte loads and stores for the load/store path.
- BUSYWAIT output stalls the PC and the register-file write.
- READDATA feeds the register-file write-data mux on loads.

Parameters:
- none; geometry is fixed: 8 blocks x 4 bytes; ADDRESS = tag[7:5] | index[4:2] | offset[1:0]

Ports:
- CLK  input  1  system clock, posedge active
- RESET  input  1  asynchronous, active-high reset
- READ  input  1  CPU load request; held until BUSYWAIT low
- WRITE  input  1  CPU store request; held until BUSYWAIT low
- ADDRESS  input  8  CPU byte address
- WRITEDATA  input  8  store data
- READDATA  output  8  load data
- BUSYWAIT  output  1  CPU stall
- MEM_READ  output  1  memory block read request
- MEM_WRITE  output  1  memory block write request
- MEM_ADDRESS  output  6  memory block address {tag,index}
- MEM_WRITEDATA  output  32  block to memory; byte0 = bits[7:0]
- MEM_READDATA  input  32  block from memory
- MEM_BUSYWAIT  input  1  memory busy

Behaviour:
- Reset: clock and reset are one CLK plus asynchronous active-high RESET.
  - All valid and dirty bits are cleared; the state register goes to IDLE.
  - BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA and READDATA all go to 0.
  - Data and tag arrays need not be cleared.
- Hit: hit = valid[index] & (tag_array[index] == tag). Evaluated combinationally.
- BUSYWAIT = (READ | WRITE) & !(state == IDLE & hit). Combinational; it rises in the same cycle as the request.
- Read hit: READDATA = data_array[index][offset] combinationally. Zero-cycle stall.
- Write hit: at posedge, the byte at offset is replaced with WRITEDATA and dirty[index] is set. Zero-cycle stall.
- READ and WRITE both high: WRITE takes priority and READDATA is don't-care. Neither high: no state change.
- FSM states: IDLE, WRITEBACK, FETCH, UPDATE.
  - IDLE -> WRITEBACK: miss and dirty[index].
  - IDLE -> FETCH: miss and !dirty[index].
  - WRITEBACK:
    - Outputs: MEM_WRITE=1, MEM_ADDRESS = {tag_array[index], index}, MEM_WRITEDATA = data_array[index].
    - Exit to FETCH at the first posedge with MEM_BUSYWAIT low, excluding the state's entry cycle. An internal issued flag masks that first cycle.
  - FETCH:
    - Outputs: MEM_READ=1, MEM_ADDRESS = {tag, index}.
    - Exit to UPDATE under the same completion rule as WRITEBACK.
  - UPDATE:
    - One cycle; MEM_READ and MEM_WRITE are 0.
    - At posedge, the block is loaded from MEM_READDATA (captured at FETCH exit), with tag set, valid=1 and dirty=0.
    - Then -> IDLE, where the access re-evaluates as a hit and completes.
- Latency, with a memory that stays busy N cycles after the request:
  - clean miss = N + 3 stall cycles;
  - dirty miss = 2N + 5 stall cycles.
- MEM_READ and MEM_WRITE are never high together. MEM_ADDRESS is held stable for the whole request.
- CPU ADDRESS, READ and WRITE must stay stable while BUSYWAIT is high; the controller does not latch them.
- RESET during WRITEBACK or FETCH: the request drops immediately (asynchronously), the state returns to IDLE and all lines become invalid. A partially written memory block is acceptable.
- Index/tag wrap: address 0xFF maps to index 7, offset 3, tag 7. There is no special casing.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined:
  - Adds output ports HIT_COUNT[15:0] and MISS_COUNT[15:0], both reset to 0.
  - HIT_COUNT increments at the posedge where a request completes in IDLE without having left IDLE.
  - MISS_COUNT increments on each IDLE->WRITEBACK or IDLE->FETCH transition.
  - Both counters saturate at 0xFFFF.
- When undefined: the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset then READ addr 0x05, memory N=4, block 0x44332211 -> MEM_READ high with MEM_ADDRESS 0x01. BUSYWAIT falls after 7 cycles; READDATA=0x22.
- Repeat READ 0x06 with no memory activity -> BUSYWAIT stays 0; READDATA=0x33 in the same cycle.
- WRITE 0xAB to 0x07 (hit), then READ 0x07 -> no stall; READDATA=0xAB; dirty[1]=1.
- READ 0x25 (same index 1, tag 1, dirty) -> MEM_WRITE with MEM_ADDRESS 0x01 and MEM_WRITEDATA 0xAB332211, then MEM_READ with MEM_ADDRESS 0x09. Total stall 13 cycles for N=4.
- Assert RESET mid-FETCH -> MEM_READ and BUSYWAIT drop immediately. A following READ 0x05 misses again.
- With DCACHE_STATS_EN defined, after the above sequence minus the reset -> HIT_COUNT=3, MISS_COUNT=2.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache: 8 blocks x 4 bytes.
// Define DCACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module dcache_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    UPDATE
  } state_e;

  state_e      state_q, state_d;
  logic        issued_q, issued_d;
  logic [7:0]  valid_q, valid_d;
  logic [7:0]  dirty_q, dirty_d;
  logic [31:0] fill_q, fill_d;
  logic [2:0]  tag_q [8];
  logic [31:0] data_q [8];

  logic        arr_we;
  logic [31:0] arr_wdata;
  logic [2:0]  arr_wtag;

  logic [2:0]  tag;
  logic [2:0]  idx;
  logic [1:0]  off;
  logic        hit;
  logic        req;
  logic        mem_done;

  assign tag      = ADDRESS[7:5];
  assign idx      = ADDRESS[4:2];
  assign off      = ADDRESS[1:0];
  assign hit      = valid_q[idx] & (tag_q[idx] == tag);
  assign req      = READ | WRITE;
  // First cycle of a memory request is masked: MEM_BUSYWAIT may lag it.
  assign mem_done = issued_q & ~MEM_BUSYWAIT;

  assign BUSYWAIT = ~RESET & req & ~((state_q == IDLE) & hit);
  assign READDATA = (~RESET & hit) ?
                    data_q[idx][{off, 3'b000} +: 8] : 8'h00;

  always_comb begin
    state_d       = state_q;
    issued_d      = 1'b0;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    fill_d        = fill_q;
    arr_we        = 1'b0;
    arr_wdata     = data_q[idx];
    arr_wtag      = tag_q[idx];
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'd0;
    MEM_WRITEDATA = 32'd0;
    unique case (state_q)
      IDLE: begin
        if (req & hit) begin
          if (WRITE) begin
            arr_we = 1'b1;
            arr_wdata[{off, 3'b000} +: 8] = WRITEDATA;
            dirty_d[idx] = 1'b1;
          end
        end else if (req) begin
          state_d = dirty_q[idx] ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[idx], idx};
        MEM_WRITEDATA = data_q[idx];
        if (mem_done) state_d = FETCH;
        else          issued_d = 1'b1;
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {tag, idx};
        if (mem_done) begin
          state_d = UPDATE;
          fill_d  = MEM_READDATA;
        end else begin
          issued_d = 1'b1;
        end
      end
      UPDATE: begin
        arr_we       = 1'b1;
        arr_wdata    = fill_q;
        arr_wtag     = tag;
        valid_d[idx] = 1'b1;
        dirty_d[idx] = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      issued_q <= 1'b0;
      valid_q  <= 8'd0;
      dirty_q  <= 8'd0;
      fill_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (arr_we) begin
      data_q[idx] <= arr_wdata;
      tag_q[idx]  <= arr_wtag;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic        missed_q, missed_d;

  // missed_q keeps the post-refill completion out of the hit count.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    missed_d   = missed_q;
    if (state_q == IDLE) begin
      if (req & hit) begin
        missed_d = 1'b0;
        if (~missed_q && hit_cnt_q != 16'hFFFF)
          hit_cnt_d = hit_cnt_q + 16'd1;
      end else if (req) begin
        missed_d = 1'b1;
        if (miss_cnt_q != 16'hFFFF)
          miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
      missed_q   <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      missed_q   <= missed_d;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed steps then random loads/stores
// checked against a flat byte-memory model and a tag/dirty latency model.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  addr = 8'd0;
  logic [7:0]  wdata = 8'd0;
  logic [7:0]  rdata;
  logic        busy;
  logic        mem_rd;
  logic        mem_wr;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_busy;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int errors = 0;
  int checks = 0;

  dcache_ctrl dut (
    .CLK          (clk),
    .RESET        (rst),
    .READ         (rd),
    .WRITE        (wr),
    .ADDRESS      (addr),
    .WRITEDATA    (wdata),
    .READDATA     (rdata),
    .BUSYWAIT     (busy),
    .MEM_READ     (mem_rd),
    .MEM_WRITE    (mem_wr),
    .MEM_ADDRESS  (mem_addr),
    .MEM_WRITEDATA(mem_wdata),
    .MEM_READDATA (mem_rdata),
    .MEM_BUSYWAIT (mem_busy)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT    (hit_count),
    .MISS_COUNT   (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory: busy N cycles from the request cycle on reads; writes need
  // one extra commit cycle before they release the bus.
  int          n_lat = 4;
  int          mcnt = 0;
  logic        preload = 1'b1;
  logic [31:0] mem [64];

  function automatic logic [31:0] init_blk(input int i);
    if (i == 1) return 32'h44332211;
    return (32'(i) + 32'd1) * 32'h9E3779B1 ^ 32'h5A5A0000;
  endfunction

  assign mem_busy = (mem_rd | mem_wr) &&
                    (mcnt < (mem_wr ? n_lat + 1 : n_lat));
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_blk(i);
      mcnt <= 0;
    end else if ((mem_rd | mem_wr) && !mem_busy) begin
      mcnt <= 0;
      if (mem_wr) mem[mem_addr] <= mem_wdata;
    end else if (mem_rd | mem_wr) begin
      mcnt <= mcnt + 1;
    end else begin
      mcnt <= 0;
    end
  end

  // Bus monitor: logs each new memory request, flags protocol breaks.
  bit          lk[$];
  logic [5:0]  la[$];
  logic [31:0] ld[$];
  logic        prev_r = 1'b0;
  logic        prev_w = 1'b0;
  logic [5:0]  prev_a = 6'd0;
  logic        excl_bad = 1'b0;
  logic        addr_bad = 1'b0;

  always @(negedge clk) begin
    if (mem_rd && mem_wr) excl_bad <= 1'b1;
    if (((mem_rd && prev_r) || (mem_wr && prev_w)) && mem_addr !== prev_a)
      addr_bad <= 1'b1;
    if (mem_wr && !prev_w) begin
      lk.push_back(1'b1);
      la.push_back(mem_addr);
      ld.push_back(mem_wdata);
    end
    if (mem_rd && !prev_r) begin
      lk.push_back(1'b0);
      la.push_back(mem_addr);
      ld.push_back(32'd0);
    end
    prev_r <= mem_rd;
    prev_w <= mem_wr;
    prev_a <= mem_addr;
  end

  // Reference model: the cache is transparent over a flat byte memory;
  // tags/dirty only decide the expected stall and bus traffic.
  logic [7:0] ref_bytes [256];
  bit         m_valid [8];
  logic [2:0] m_tag [8];
  bit         m_dirty [8];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic access(input bit is_wr, input logic [7:0] a,
                        input logic [7:0] d);
    logic [2:0]  t;
    logic [2:0]  ix;
    logic [2:0]  old_t;
    logic [31:0] old_blk;
    bit          miss;
    bit          was_dirty;
    int          cyc;
    int          exp_lat;
    int          n_exp;
    t         = a[7:5];
    ix        = a[4:2];
    old_t     = m_tag[ix];
    miss      = !(m_valid[ix] && m_tag[ix] == t);
    was_dirty = miss && m_dirty[ix];
    old_blk   = {ref_bytes[{old_t, ix, 2'd3}], ref_bytes[{old_t, ix, 2'd2}],
                 ref_bytes[{old_t, ix, 2'd1}], ref_bytes[{old_t, ix, 2'd0}]};
    exp_lat   = !miss ? 0 : (was_dirty ? 2 * n_lat + 5 : n_lat + 3);
    n_exp     = (miss ? 1 : 0) + (was_dirty ? 1 : 0);
    lk.delete();
    la.delete();
    ld.delete();
    @(posedge clk);
    #1;
    rd    = !is_wr;
    wr    = is_wr;
    addr  = a;
    wdata = d;
    #1;
    cyc = 0;
    while (busy && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk($sformatf("latency@%0h", a), cyc, exp_lat);
    if (!is_wr) chk($sformatf("readdata@%0h", a), rdata, ref_bytes[a]);
    @(posedge clk);
    #1;
    rd = 1'b0;
    wr = 1'b0;
    chk($sformatf("memlog_len@%0h", a), lk.size(), n_exp);
    if (lk.size() == n_exp && was_dirty) begin
      chk("wb_kind", 32'(lk[0]), 32'd1);
      chk("wb_addr", la[0], {old_t, ix});
      chk("wb_data", ld[0], old_blk);
    end
    if (lk.size() == n_exp && miss) begin
      chk("fetch_kind", 32'(lk[n_exp - 1]), 32'd0);
      chk("fetch_addr", la[n_exp - 1], {t, ix});
    end
    if (miss) begin
      m_valid[ix] = 1'b1;
      m_tag[ix]   = t;
      m_dirty[ix] = 1'b0;
    end
    if (is_wr) begin
      ref_bytes[a] = d;
      m_dirty[ix]  = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] blk;
    logic [2:0]  tg;
    logic [4:0]  lo;
    int          cyc;
    for (int i = 0; i < 256; i++) begin
      blk = init_blk(i / 4);
      ref_bytes[i] = blk[(i % 4) * 8 +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 3'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busywait", busy, 0);
    chk("rst_mem_read", mem_rd, 0);
    chk("rst_mem_write", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_readdata", rdata, 0);
    preload = 1'b0;
    rst     = 1'b0;

    n_lat = 4;
    access(1'b0, 8'h05, 8'h00);
    access(1'b0, 8'h06, 8'h00);
    access(1'b1, 8'h07, 8'hAB);
    access(1'b0, 8'h07, 8'h00);
    access(1'b0, 8'h25, 8'h00);
`ifdef DCACHE_STATS_EN
    chk("hit_count", hit_count, 3);
    chk("miss_count", miss_count, 2);
`endif

    // Reset in the middle of a refill.
    @(posedge clk);
    #1;
    rd   = 1'b1;
    addr = 8'h05;
    cyc  = 0;
    while (!mem_rd && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("fetch_started", mem_rd, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_mem_read", mem_rd, 0);
    chk("midrst_busywait", busy, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_readdata", rdata, 0);
`ifdef DCACHE_STATS_EN
    chk("midrst_hits", hit_count, 0);
    chk("midrst_misses", miss_count, 0);
`endif
    @(posedge clk);
    #1;
    rd = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    access(1'b0, 8'h05, 8'h00);

    n_lat = 2;
    access(1'b1, 8'hFF, 8'h5C);
    access(1'b0, 8'hFF, 8'h00);
    access(1'b0, 8'h1F, 8'h00);
    access(1'b0, 8'hFC, 8'h00);

    for (int k = 0; k < 200; k++) begin
      n_lat = $urandom_range(1, 6);
      tg    = 3'($urandom_range(0, 2));
      lo    = 5'($urandom);
      access(1'($urandom_range(0, 1)), {tg, lo}, 8'($urandom));
    end

    chk("mem_rd_wr_exclusive", excl_bad, 0);
    chk("mem_addr_stable", addr_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
